// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants: FSM state encoding, oversampling
// ratio, and the three mid-bit sample phases.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } rx_state_e;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned PH_W       = $clog2(OVERSAMPLE);
   localparam int unsigned DATA_BITS  = 8;

   localparam logic [PH_W-1:0] SAMPLE_PH0 = PH_W'(7);
   localparam logic [PH_W-1:0] SAMPLE_PH1 = PH_W'(8);
   localparam logic [PH_W-1:0] SAMPLE_PH2 = PH_W'(9);
   localparam logic [3:0]      LAST_BIT   = 4'(DATA_BITS - 1);

   function automatic logic majority3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte bus: data, one-cycle valid strobe and the per-frame error flags.
interface uart_rx_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;

   modport master (output rx_data, rx_valid, parity_err, frame_err);
   modport slave  (input  rx_data, rx_valid, parity_err, frame_err);

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous input, with a selectable reset level.
module uart_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic rst_val_i,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {2{rst_val_i}};
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, majority-of-three bit decisions, 8 data bits
// LSB first, optional parity, one stop bit; per-frame parity/framing flags.
module uart_rx (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     baud_tick_x16_i,
   input  logic     rx_en_i,
   input  logic     parity_en_i,
   input  logic     parity_odd_i,
   input  logic     rx_i,
   uart_rx_if.master rx_if
);

   import uart_pkg::*;

   logic            rx_s;
   rx_state_e       state_q;
   logic [PH_W-1:0] phase_q;
   logic [3:0]      bit_q;
   logic [2:0]      samp_q;
   logic [7:0]      shift_q;
   logic [7:0]      data_q;
   logic            par_bit_q;
   logic            par_en_q;
   logic            par_odd_q;
   logic            valid_q;
   logic            perr_q;
   logic            ferr_q;
   logic            bit_dec;
   logic            at_center;

   uart_sync u_sync (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .rst_val_i (1'b1),
      .d_i       (rx_i),
      .q_o       (rx_s)
   );

   // The phase-9 sample is the one being captured this tick, so it joins the vote directly.
   assign bit_dec   = majority3({samp_q[1:0], rx_s});
   assign at_center = (phase_q == SAMPLE_PH2);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         bit_q     <= '0;
         samp_q    <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         par_bit_q <= 1'b0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (!rx_en_i) begin
            state_q <= IDLE;
         end else if (baud_tick_x16_i) begin
            if (state_q inside {START, DATA, PARITY, STOP}) begin
               phase_q <= phase_q + 1'b1;
               if (phase_q inside {SAMPLE_PH0, SAMPLE_PH1, SAMPLE_PH2}) begin
                  samp_q <= {samp_q[1:0], rx_s};
               end
            end
            case (state_q)
               IDLE: begin
                  if (!rx_s) begin
                     state_q <= START;
                     phase_q <= '0;
                  end
               end
               START: begin
                  if (at_center) begin
                     if (bit_dec) begin
                        state_q <= IDLE;
                     end else begin
                        state_q   <= DATA;
                        bit_q     <= '0;
                        par_en_q  <= parity_en_i;
                        par_odd_q <= parity_odd_i;
                     end
                  end
               end
               DATA: begin
                  if (at_center) begin
                     shift_q <= {bit_dec, shift_q[7:1]};
                     if (bit_q == LAST_BIT) begin
                        bit_q   <= '0;
                        state_q <= par_en_q ? PARITY : STOP;
                     end else begin
                        bit_q <= bit_q + 1'b1;
                     end
                  end
               end
               PARITY: begin
                  if (at_center) begin
                     par_bit_q <= bit_dec;
                     state_q   <= STOP;
                  end
               end
               STOP: begin
                  if (at_center) begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                     perr_q  <= par_en_q & (par_bit_q != ((^shift_q) ^ par_odd_q));
                     ferr_q  <= ~bit_dec;
                     state_q <= bit_dec ? IDLE : WAIT_HIGH;
                  end
               end
               WAIT_HIGH: begin
                  if (rx_s) begin
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign rx_if.rx_data    = data_q;
   assign rx_if.rx_valid   = valid_q;
   assign rx_if.parity_err = perr_q;
   assign rx_if.frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: frames are driven at 16 ticks/bit
// with one tick every 4 clocks; a negedge monitor captures every strobe.
module tb_uart_rx;

   import uart_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0;
   logic rx_en = 1'b1;
   logic par_en = 1'b0;
   logic par_odd = 1'b0;
   logic rx = 1'b1;

   int checks = 0;
   int errors = 0;

   uart_rx_if rif ();

   uart_rx dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .baud_tick_x16_i (tick),
      .rx_en_i         (rx_en),
      .parity_en_i     (par_en),
      .parity_odd_i    (par_odd),
      .rx_i            (rx),
      .rx_if           (rif)
   );

   always #5 clk = ~clk;

   // Strobe monitor: records each received frame and the frame-local tick it followed.
   logic [7:0] cap_data [0:63];
   logic       cap_perr [0:63];
   logic       cap_ferr [0:63];
   int         strobe_cnt  = 0;
   int         wide_cnt    = 0;
   int         strobe_tick = -1;
   int         cur_tick    = 0;
   logic       prev_valid  = 1'b0;

   always @(negedge clk) begin
      if (rif.rx_valid) begin
         cap_data[strobe_cnt[5:0]] <= rif.rx_data;
         cap_perr[strobe_cnt[5:0]] <= rif.parity_err;
         cap_ferr[strobe_cnt[5:0]] <= rif.frame_err;
         strobe_cnt  <= strobe_cnt + 1;
         strobe_tick <= cur_tick;
         if (prev_valid) wide_cnt <= wide_cnt + 1;
      end
      prev_valid <= rif.rx_valid;
   end

   task automatic do_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic line(input logic b, input int n);
      rx = b;
      repeat (n) do_tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                             input logic stop, input int glitch_bit, input int glitch_idx);
      logic [10:0] bits;
      int nb;
      bits = '1;
      bits[0] = 1'b0;
      bits[8:1] = d;
      if (has_par) begin
         bits[9] = pbit;
         bits[10] = stop;
         nb = 11;
      end else begin
         bits[9] = stop;
         nb = 10;
      end
      cur_tick = 0;
      for (int b = 0; b < nb; b++) begin
         for (int t = 0; t < 16; t++) begin
            rx = (b == glitch_bit && t == glitch_idx) ? ~bits[b] : bits[b];
            do_tick();
            cur_tick = cur_tick + 1;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (rif.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rif.rx_data); end
      checks++; if (rif.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rif.rx_valid); end
      checks++; if (rif.parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", rif.parity_err); end
      checks++; if (rif.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", rif.frame_err); end
      rst = 1'b0;
      line(1'b1, 4);
   endtask

   task automatic test_no_parity();
      int base;
      base = strobe_cnt;
      par_en = 1'b0;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, -1);
      line(1'b1, 2);
      checks++; if (strobe_cnt - base !== 1) begin errors++; $display("FAIL nopar_count: got %0d expected 1", strobe_cnt - base); end
      checks++; if (cap_data[base[5:0]] !== 8'hA5) begin errors++; $display("FAIL nopar_data: got %h expected a5", cap_data[base[5:0]]); end
      checks++; if (cap_perr[base[5:0]] !== 1'b0) begin errors++; $display("FAIL nopar_perr: got %b expected 0", cap_perr[base[5:0]]); end
      checks++; if (cap_ferr[base[5:0]] !== 1'b0) begin errors++; $display("FAIL nopar_ferr: got %b expected 0", cap_ferr[base[5:0]]); end
      checks++; if (strobe_tick !== 155) begin errors++; $display("FAIL nopar_latency: got tick %0d expected 155", strobe_tick); end
   endtask

   task automatic test_parity();
      int base;
      par_en = 1'b1;
      par_odd = 1'b0;
      base = strobe_cnt;
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1, -1);
      line(1'b1, 2);
      checks++; if (cap_data[base[5:0]] !== 8'h3C) begin errors++; $display("FAIL par_good_data: got %h expected 3c", cap_data[base[5:0]]); end
      checks++; if (cap_perr[base[5:0]] !== 1'b0) begin errors++; $display("FAIL par_good_perr: got %b expected 0", cap_perr[base[5:0]]); end
      checks++; if (strobe_tick !== 171) begin errors++; $display("FAIL par_latency: got tick %0d expected 171", strobe_tick); end
      base = strobe_cnt;
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1, -1);
      line(1'b1, 2);
      checks++; if (strobe_cnt - base !== 1) begin errors++; $display("FAIL par_bad_count: got %0d expected 1", strobe_cnt - base); end
      checks++; if (cap_data[base[5:0]] !== 8'h3C) begin errors++; $display("FAIL par_bad_data: got %h expected 3c", cap_data[base[5:0]]); end
      checks++; if (cap_perr[base[5:0]] !== 1'b1) begin errors++; $display("FAIL par_bad_perr: got %b expected 1", cap_perr[base[5:0]]); end
      par_en = 1'b0;
   endtask

   task automatic test_frame_err();
      int base;
      base = strobe_cnt;
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, -1, -1);
      line(1'b0, 40);
      line(1'b1, 4);
      checks++; if (strobe_cnt - base !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", strobe_cnt - base); end
      checks++; if (cap_data[base[5:0]] !== 8'hC3) begin errors++; $display("FAIL ferr_data: got %h expected c3", cap_data[base[5:0]]); end
      checks++; if (cap_ferr[base[5:0]] !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", cap_ferr[base[5:0]]); end
      base = strobe_cnt;
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, -1);
      line(1'b1, 2);
      checks++; if (strobe_cnt - base !== 1) begin errors++; $display("FAIL ferr_next_count: got %0d expected 1", strobe_cnt - base); end
      checks++; if (cap_data[base[5:0]] !== 8'h55) begin errors++; $display("FAIL ferr_next_data: got %h expected 55", cap_data[base[5:0]]); end
      checks++; if (cap_ferr[base[5:0]] !== 1'b0) begin errors++; $display("FAIL ferr_next_flag: got %b expected 0", cap_ferr[base[5:0]]); end
   endtask

   task automatic test_start_glitch();
      int base;
      base = strobe_cnt;
      line(1'b0, 5);
      line(1'b1, 30);
      checks++; if (strobe_cnt - base !== 0) begin errors++; $display("FAIL glitch_start_count: got %0d expected 0", strobe_cnt - base); end
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL glitch_start_state: got %0d expected %0d", dut.state_q, IDLE); end
   endtask

   task automatic test_disable();
      int base;
      base = strobe_cnt;
      line(1'b0, 16);
      line(1'b1, 8);
      rx_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL disable_state: got %0d expected %0d", dut.state_q, IDLE); end
      rx_en = 1'b1;
      line(1'b1, 200);
      checks++; if (strobe_cnt - base !== 0) begin errors++; $display("FAIL disable_count: got %0d expected 0", strobe_cnt - base); end
      checks++; if (rif.rx_data !== 8'h55) begin errors++; $display("FAIL disable_hold: got %h expected 55", rif.rx_data); end
   endtask

   task automatic test_glitch_reset();
      int base;
      base = strobe_cnt;
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 4, 9);
      line(1'b1, 2);
      checks++; if (cap_data[base[5:0]] !== 8'hFF) begin errors++; $display("FAIL vote_data: got %h expected ff", cap_data[base[5:0]]); end
      checks++; if (strobe_cnt - base !== 1) begin errors++; $display("FAIL vote_count: got %0d expected 1", strobe_cnt - base); end
      // Second frame: start + data bits 0..3 of 0xFF, reset midway through bit 4.
      line(1'b0, 16);
      line(1'b1, 64);
      line(1'b1, 8);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (rif.rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", rif.rx_data); end
      checks++; if (rif.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", rif.rx_valid); end
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_mid_state: got %0d expected %0d", dut.state_q, IDLE); end
      line(1'b1, 20);
      base = strobe_cnt;
      send_frame(8'h12, 1'b0, 1'b0, 1'b1, -1, -1);
      line(1'b1, 2);
      checks++; if (strobe_cnt - base !== 1) begin errors++; $display("FAIL rst_next_count: got %0d expected 1", strobe_cnt - base); end
      checks++; if (cap_data[base[5:0]] !== 8'h12) begin errors++; $display("FAIL rst_next_data: got %h expected 12", cap_data[base[5:0]]); end
      checks++; if (cap_ferr[base[5:0]] !== 1'b0) begin errors++; $display("FAIL rst_next_ferr: got %b expected 0", cap_ferr[base[5:0]]); end
   endtask

   task automatic test_back_to_back();
      int base;
      logic [7:0] exp_d [0:2];
      exp_d[0] = 8'h00;
      exp_d[1] = 8'hFF;
      exp_d[2] = 8'h81;
      par_en = 1'b1;
      par_odd = 1'b1;
      base = strobe_cnt;
      // Odd parity bit for 0x00, 0xFF and 0x81 is 1 in every case.
      for (int i = 0; i < 3; i++) send_frame(exp_d[i], 1'b1, 1'b1, 1'b1, -1, -1);
      line(1'b1, 4);
      checks++; if (strobe_cnt - base !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", strobe_cnt - base); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (cap_data[6'(base + i)] !== exp_d[i]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, cap_data[6'(base + i)], exp_d[i]); end
         checks++; if (cap_perr[6'(base + i)] !== 1'b0) begin errors++; $display("FAIL b2b_perr%0d: got %b expected 0", i, cap_perr[6'(base + i)]); end
         checks++; if (cap_ferr[6'(base + i)] !== 1'b0) begin errors++; $display("FAIL b2b_ferr%0d: got %b expected 0", i, cap_ferr[6'(base + i)]); end
      end
      checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL strobe_width: got %0d long strobes expected 0", wide_cnt); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_no_parity();
      test_parity();
      test_frame_err();
      test_start_glitch();
      test_disable();
      test_glitch_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
